mux6_rr_scheduler: RTL and testbench

- Round-robin scheduler that shares one 6-to-1 selector datapath among up to 6 requesters.
- Arbitrates request lines and holds each grant for one transaction, with optional timeout preemption.
- Drives the 3-bit mux select (MSB = MuxSelect0 of the mux), a one-hot grant vector and a select-valid qualifier.
- Sits between board-level request sources (SW/KEY-derived or internal) and the mux select inputs.

---
 rtl/mux6_rr_scheduler_pkg.sv | 22 ++
 rtl/mux6_rr_scheduler_if.sv | 25 ++
 rtl/mux6_rr_scheduler_rr_pick.sv | 31 +++
 rtl/mux6_rr_scheduler.sv | 118 +++++++++++
 tb/tb_mux6_rr_scheduler.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/mux6_rr_scheduler_pkg.sv
// mux_sched_pkg: shared state encoding, defaults and helpers for the
// round-robin mux scheduler (timeout build: MUX6_SCHED_TIMEOUT_EN).
package mux_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01,
    GUARD = 2'b10
  } state_t;

  localparam int DEF_NUM_REQ  = 6;
  localparam int DEF_SEL_W    = 3;
  localparam int DEF_MAX_HOLD = 16;
  localparam int HOLD_W       = 8;

  function automatic logic [DEF_NUM_REQ-1:0] onehot(
    input logic [DEF_SEL_W-1:0] idx
  );
    onehot = DEF_NUM_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/mux6_rr_scheduler_if.sv
// Request/grant bundle between requesters and the mux scheduler.
// Same signal set in both builds (MUX6_SCHED_TIMEOUT_EN adds no ports).
interface mux6_rr_scheduler_if
  import mux_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int SEL_W   = DEF_SEL_W
);
  logic               Enable;
  logic [NUM_REQ-1:0] Req;
  logic [NUM_REQ-1:0] Grant;
  logic [SEL_W-1:0]   MuxSelect;
  logic               SelValid;
  logic               Preempt;

  modport master (
    input  Enable, Req,
    output Grant, MuxSelect, SelValid, Preempt
  );

  modport slave (
    output Enable, Req,
    input  Grant, MuxSelect, SelValid, Preempt
  );
endinterface

// File: rtl/mux6_rr_scheduler_rr_pick.sv
// rr_pick: combinational rotating priority encoder, first set req
// at or after ptr, wrapping modulo N.
module rr_pick #(
  parameter int N = 6,
  parameter int W = 3
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] idx
);
  int         j;
  logic [W-1:0] jw;

  // Scan from lowest priority down so the last hit wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = 0;
    jw    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      jw = W'(j);
      if (req[jw]) begin
        found = 1'b1;
        idx   = jw;
      end
    end
  end
endmodule

// File: rtl/mux6_rr_scheduler.sv
// mux6_rr_scheduler: round-robin owner of a shared 6:1 mux select.
// Define MUX6_SCHED_TIMEOUT_EN for MAX_HOLD forced release + Preempt.
module mux6_rr_scheduler
  import mux_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int SEL_W   = DEF_SEL_W
`ifdef MUX6_SCHED_TIMEOUT_EN
  , parameter int MAX_HOLD = DEF_MAX_HOLD
`endif
) (
  input logic Clock,
  input logic Resetn,
  mux6_rr_scheduler_if.master bus
);
  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               valid_q, valid_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [SEL_W-1:0]   nxt_ptr;
  logic               found;
  logic [SEL_W-1:0]   pick;
`ifdef MUX6_SCHED_TIMEOUT_EN
  logic [HOLD_W-1:0]  cnt_q, cnt_d;
  logic               pre_q, pre_d;
`endif

  rr_pick #(.N(NUM_REQ), .W(SEL_W)) u_pick (
    .req  (bus.Req),
    .ptr  (ptr_q),
    .found(found),
    .idx  (pick)
  );

  assign nxt_ptr = (sel_q == SEL_W'(NUM_REQ - 1)) ? '0 : sel_q + 1'b1;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
`ifdef MUX6_SCHED_TIMEOUT_EN
    cnt_d   = cnt_q;
    pre_d   = 1'b0;
`endif
    unique case (1'b1)
      (state_q == GRANT): begin
`ifdef MUX6_SCHED_TIMEOUT_EN
        cnt_d = cnt_q + 1'b1;
`endif
        if (!bus.Req[sel_q]) begin
          state_d = GUARD;
          grant_d = '0;
          valid_d = 1'b0;
          ptr_d   = nxt_ptr;
`ifdef MUX6_SCHED_TIMEOUT_EN
        end else if (cnt_q == HOLD_W'(MAX_HOLD - 1)) begin
          state_d = GUARD;
          grant_d = '0;
          valid_d = 1'b0;
          ptr_d   = nxt_ptr;
          pre_d   = 1'b1;
`endif
        end
      end
      // IDLE and GUARD both arbitrate; MuxSelect keeps the last owner.
      default: begin
        state_d = IDLE;
        grant_d = '0;
        valid_d = 1'b0;
        if (bus.Enable && found) begin
          state_d = GRANT;
          grant_d = NUM_REQ'(onehot(DEF_SEL_W'(pick)));
          sel_d   = pick;
          valid_d = 1'b1;
`ifdef MUX6_SCHED_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= IDLE;
      grant_q <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
`ifdef MUX6_SCHED_TIMEOUT_EN
      cnt_q   <= '0;
      pre_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
`ifdef MUX6_SCHED_TIMEOUT_EN
      cnt_q   <= cnt_d;
      pre_q   <= pre_d;
`endif
    end
  end

  assign bus.Grant     = grant_q;
  assign bus.MuxSelect = sel_q;
  assign bus.SelValid  = valid_q;
`ifdef MUX6_SCHED_TIMEOUT_EN
  assign bus.Preempt   = pre_q;
`else
  assign bus.Preempt   = 1'b0;
`endif
endmodule

// File: tb/tb_mux6_rr_scheduler.sv
// Directed scoreboard bench for mux6_rr_scheduler; timeout checks
// follow MUX6_SCHED_TIMEOUT_EN.
module tb_mux6_rr_scheduler;
  import mux_sched_pkg::*;

  localparam int N = DEF_NUM_REQ;
  localparam int W = DEF_SEL_W;

  logic Clock = 1'b0;
  logic Resetn = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   exp_q[$];
  int   hold;
  int   seen;

  mux6_rr_scheduler_if #(.NUM_REQ(N), .SEL_W(W)) bus ();

  mux6_rr_scheduler #(.NUM_REQ(N), .SEL_W(W)) dut (
    .Clock (Clock),
    .Resetn(Resetn),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic expect_grant(input string tag, input int maxc);
    int n;
    int idx;
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.SelValid && n < maxc);
    chk({tag, "_valid"}, 32'(bus.SelValid), 1);
    chk({tag, "_sbq"}, 32'(exp_q.size() != 0), 1);
    if (exp_q.size() != 0) begin
      idx = exp_q.pop_front();
      chk({tag, "_sel"}, 32'(bus.MuxSelect), idx);
      chk({tag, "_grant"}, 32'(bus.Grant), 32'(1) << idx);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    bus.Enable = 1'b0;
    bus.Req    = '0;
    tick();
    chk("rst_grant", 32'(bus.Grant), 0);
    chk("rst_sel", 32'(bus.MuxSelect), 0);
    chk("rst_valid", 32'(bus.SelValid), 0);
    chk("rst_pre", 32'(bus.Preempt), 0);
    tick();
    Resetn = 1'b1;
    tick();

    // reset in the middle of a grant
    bus.Enable = 1'b1;
    bus.Req    = 6'b000100;
    exp_q.push_back(2);
    expect_grant("mid_first", 1);
    tick();
    tick();
    #2;
    Resetn = 1'b0;
    #1;
    chk("mid_rst_grant", 32'(bus.Grant), 0);
    chk("mid_rst_valid", 32'(bus.SelValid), 0);
    chk("mid_rst_sel", 32'(bus.MuxSelect), 0);
    tick();
    Resetn = 1'b1;
    exp_q.push_back(2);
    expect_grant("mid_regrant", 1);
    bus.Req = '0;
    tick();
    tick();

    // single requester, five-cycle transaction
    bus.Req = 6'b001000;
    exp_q.push_back(3);
    expect_grant("single", 1);
    hold = 1;
    repeat (4) begin
      tick();
      if (bus.SelValid && bus.MuxSelect == 3) hold++;
    end
    bus.Req = '0;
    tick();
    chk("single_hold", hold, 5);
    chk("single_guard_valid", 32'(bus.SelValid), 0);
    chk("single_guard_grant", 32'(bus.Grant), 0);
    chk("single_guard_sel", 32'(bus.MuxSelect), 3);
    tick();
    chk("single_idle_valid", 32'(bus.SelValid), 0);

    // fairness with pointer wrap, from a fresh pointer
    Resetn = 1'b0;
    #1;
    Resetn = 1'b1;
    bus.Req = '1;
    for (int k = 0; k < 7; k++) exp_q.push_back(k % N);
    for (int k = 0; k < 7; k++) begin
      expect_grant("fair", 1);
      tick();
      bus.Req[k % N] = 1'b0;
      tick();
      chk("fair_guard_valid", 32'(bus.SelValid), 0);
      chk("fair_guard_sel", 32'(bus.MuxSelect), k % N);
      bus.Req[k % N] = 1'b1;
    end
    bus.Req = '0;
    tick();
    tick();

    // long hold: preempted in timeout build, persistent otherwise
    bus.Req = 6'b010100;
    exp_q.push_back(2);
    expect_grant("to_first", 1);
    hold = 1;
`ifdef MUX6_SCHED_TIMEOUT_EN
    while (bus.SelValid && hold < 40) begin
      tick();
      if (bus.SelValid) hold++;
    end
    chk("to_hold", hold, DEF_MAX_HOLD);
    chk("to_pre", 32'(bus.Preempt), 1);
    chk("to_guard_grant", 32'(bus.Grant), 0);
    exp_q.push_back(4);
    expect_grant("to_next", 1);
    chk("to_pre_clear", 32'(bus.Preempt), 0);
`else
    repeat (39) begin
      tick();
      if (bus.SelValid && bus.Grant == 6'b000100) hold++;
      if (bus.Preempt) hold = -100;
    end
    chk("persist_hold", hold, 40);
`endif
    bus.Req = '0;
    tick();
    chk("to_release_valid", 32'(bus.SelValid), 0);
    tick();

    // Enable gating, plus wrap to requester 0
    bus.Enable = 1'b0;
    bus.Req    = 6'b000011;
    seen = 0;
    repeat (10) begin
      tick();
      if (bus.SelValid) seen++;
    end
    chk("en_block", seen, 0);
    bus.Enable = 1'b1;
    exp_q.push_back(0);
    expect_grant("en_go", 1);
    bus.Enable = 1'b0;
    repeat (3) tick();
    chk("en_inflight", 32'(bus.SelValid), 1);
    bus.Req = 6'b000010;
    tick();
    chk("en_guard", 32'(bus.SelValid), 0);
    seen = 0;
    repeat (4) begin
      tick();
      if (bus.SelValid) seen++;
    end
    chk("en_block2", seen, 0);
    bus.Enable = 1'b1;
    exp_q.push_back(1);
    expect_grant("en_next", 1);
    bus.Req = '0;
    tick();
    tick();

    // owner drops exactly at the last allowed hold cycle
    bus.Req = 6'b100000;
    exp_q.push_back(5);
    expect_grant("sim", 1);
    repeat (DEF_MAX_HOLD - 1) tick();
    chk("sim_hold", 32'(bus.SelValid), 1);
    bus.Req = '0;
    tick();
    chk("sim_guard_valid", 32'(bus.SelValid), 0);
    chk("sim_pre", 32'(bus.Preempt), 0);
    tick();
    chk("sim_sbq_empty", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
